clk_div_n: RTL and testbench
============================

# clk_div_n

Parametrised multi-channel clock divider, successor to the fixed two-output 1 kHz / 1 s divider. From the board clock `clk_25M` it generates `N_CH` independent square-wave divided clocks plus a one-cycle tick strobe per channel. Each channel has a per-channel enable and a half-period that can be reloaded at run time, glitch-free. A global sync input phase-aligns all channels. It feeds LED scanning, blink timing and any block needing slow periodic strobes.

## Interface
- `N_CH`, 2: number of output channels, 1..16.
- `CNT_W`, 25: counter and half-period width in bits.
- `HALF_INIT`, {25'd12499999, 25'd12499}: packed `N_CH*CNT_W` reset half-periods; channel 0 is in the LSBs.
- `clk_25M`, in, 1: system clock; all logic is on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `en`, in, `N_CH`: per-channel count enable.
- `sync`, in, 1: one-cycle pulse that restarts all channels in phase.
- `cfg_wr`, in, 1: half-period write request.
- `cfg_ch`, in, `CH_W = max(1, $clog2(N_CH))`: target channel of the write.
- `cfg_half`, in, `CNT_W`: new half-period value.
- `cfg_ready`, out, 1: write slot free; a write is accepted when `cfg_wr & cfg_ready`.
- `clk_out`, out, `N_CH`: divided square waves, registered.
- `tick`, out, `N_CH`: one-cycle pulse, asserted in the cycle `clk_out[i]` goes 0→1.

## Operation
- **Reset values:** `clk_out` = all 1; `tick` = 0; all counters = 0; `half[i]` = `HALF_INIT[i]`; `cfg_ready` = 1; pending slot empty.
- **Channel `i` when `en[i]` = 1:**
  - If `cnt >= half`: toggle `clk_out`, set `cnt <= 0`, set `tick <= ~clk_out` (pulse only on the rising toggle).
  - Otherwise: `cnt <= cnt + 1`, `tick <= 0`.
  - Output period is `2*(half+1)` cycles at 50 % duty. `half = 0` divides by 2.
- **Channel `i` when `en[i]` = 0:** `cnt` and `clk_out` hold; `tick` = 0.
- **Config write:**
  - One shared pending slot holds `{ch, value}`. An accepted write fills the slot, and `cfg_ready` drops the next cycle.
  - The slot applies at the target channel's next toggle: `half` is updated and the counter restarts at 0 with the new value. The current half-period therefore always completes, so there is no runt pulse.
  - If the target channel is disabled, the slot applies on the next cycle; `cnt` is set to 0 and `clk_out` holds.
  - `cfg_ch >= N_CH`: the write is accepted and discarded, and `cfg_ready` stays 1.
  - `cfg_ready` returns to 1 in the cycle after the apply.
- **Sync:** sets every `cnt` to 0, every `clk_out` to 1 and every `tick` to 0, regardless of `en`. A pending slot is applied at the same time.
- **Priority:** `reset` > `sync` > normal count or apply.
- **Same-cycle sync and write:** a write accepted in the same cycle as `sync` is captured into the slot and applied at the target's next toggle after the sync.
- **`cnt > half` after reload:** impossible, because the counter is zeroed at apply. The `>=` comparison is still kept for robustness.
- **Reset mid-operation:** a pending write is lost; `half` returns to `HALF_INIT`.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- First toggle after reset release, with `en` = 1: `clk_out` falls on the `(half+1)`-th enabled edge and rises on the `2*(half+1)`-th. `tick` is high for exactly that rising cycle.
- Write to a busy channel: latency from acceptance to the new period taking effect is at most `half_old + 1` cycles.
- Write to a disabled channel: takes effect in 1 cycle.
- `sync` takes effect on the edge that samples it. The first falling edge follows `half+1` cycles later.

## Structure
- Package `clk_div_pkg`:
  - constants `CLK_HZ = 25_000_000`;
  - the function `half_for_hz(f) = CLK_HZ/(2f) - 1`;
  - the default half-periods `HALF_1K = 12499` and `HALF_1S = 12499999`.
- Sub-module `clk_div_ch`: one channel, holding the counter, half register, toggle, tick and a load port (`ld`, `ld_val`). It is instantiated `N_CH` times with a generate loop.
- Top level: the pending slot, the `cfg_ready` logic and the fan-out of `sync`.

## Test plan
- **Reset defaults:** `HALF_INIT` = {3, 1}, `en` = 11 after reset.
  - ch0: period 4, falls at cycle 2, rises at cycle 4.
  - ch1: period 8, falls at cycle 4, rises at cycle 8.
  - `tick` pulses of exactly 1 cycle at cycles 4 / 8, 12 / 16, and so on.
- **Enable gating:** drop `en[1]` mid-count for 5 cycles → `clk_out[1]` and its count freeze, and `tick[1]` = 0. On re-enable, counting resumes from the held count.
- **Glitch-free reload:** ch1 `half` = 3. Write `half` = 1 at count 1 → `cfg_ready` low, the old half-period completes, then every subsequent half-period is 2 cycles and `cfg_ready` returns high.
- **Write to a disabled channel / invalid channel:**
  - Write to ch0 with `en[0]` = 0 → `half` updates in 1 cycle.
  - Write with `cfg_ch` = 3 at `N_CH` = 2 → no state change, and `cfg_ready` stays 1.
- **Sync:** pulse `sync` with the channels out of phase → both `clk_out` = 1 next cycle with counters at 0, and the falling edges land at `half+1` cycles. With `sync` and `cfg_wr` in the same cycle, the write is applied at the next toggle.
- **Reset mid-operation:** assert `reset` while a write is pending → all reset values are restored, `cfg_ready` = 1, and the `HALF_INIT` periods resume.

Source files
------------

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and helpers for the multi-channel clock divider
package clk_div_pkg;

   localparam int unsigned CLK_HZ = 25_000_000;

   // Half-period count (0-based) giving a square wave of f Hz from CLK_HZ
   function automatic int unsigned half_for_hz(input int unsigned f);
      return CLK_HZ / (2 * f) - 1;
   endfunction

   localparam int unsigned HALF_1K = half_for_hz(1_000);
   localparam int unsigned HALF_1S = half_for_hz(1);

endpackage

// File: rtl/clk_div_ch.sv
// rtl/clk_div_ch.sv - one divider channel: counter, half-period register, toggle, tick, reload
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int               CNT_W    = 25,
   parameter logic [CNT_W-1:0] HALF_RST = CNT_W'(HALF_1K)
) (
   input  logic             clk_25M,
   input  logic             reset,
   input  logic             en,
   input  logic             sync,
   input  logic             ld,
   input  logic [CNT_W-1:0] ld_val,
   output logic             ld_ack,
   output logic             clk_out,
   output logic             tick
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_half;
   logic             r_clk_out;
   logic             r_tick;
   logic             w_wrap;

   // >= rather than == so a corrupted counter can never run away past half
   assign w_wrap = (r_cnt >= r_half);

   // A pending reload lands only where the counter restarts anyway, so no runt half-period
   assign ld_ack = ld & (sync | ~en | w_wrap);

   // Counter, output phase and reload; reset beats sync beats normal counting
   always_ff @(posedge clk_25M) begin
      if (reset) begin
         r_cnt     <= '0;
         r_half    <= HALF_RST;
         r_clk_out <= 1'b1;
         r_tick    <= 1'b0;
      end else if (sync) begin
         r_cnt     <= '0;
         r_clk_out <= 1'b1;
         r_tick    <= 1'b0;
         if (ld) r_half <= ld_val;
      end else if (!en) begin
         r_tick <= 1'b0;
         if (ld) begin
            r_half <= ld_val;
            r_cnt  <= '0;
         end
      end else if (w_wrap) begin
         r_clk_out <= ~r_clk_out;
         r_cnt     <= '0;
         r_tick    <= ~r_clk_out;
         if (ld) r_half <= ld_val;
      end else begin
         r_cnt  <= r_cnt + CNT_W'(1);
         r_tick <= 1'b0;
      end
   end

   assign clk_out = r_clk_out;
   assign tick    = r_tick;

endmodule

// File: rtl/clk_div_n.sv
// rtl/clk_div_n.sv - N-channel clock divider with shared reload slot and global sync
module clk_div_n
   import clk_div_pkg::*;
#(
   parameter int                     N_CH      = 2,
   parameter int                     CNT_W     = 25,
   parameter logic [N_CH*CNT_W-1:0]  HALF_INIT = {CNT_W'(HALF_1S), CNT_W'(HALF_1K)},
   localparam int                    CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk_25M,
   input  logic             reset,
   input  logic [N_CH-1:0]  en,
   input  logic             sync,
   input  logic             cfg_wr,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [CNT_W-1:0] cfg_half,
   output logic             cfg_ready,
   output logic [N_CH-1:0]  clk_out,
   output logic [N_CH-1:0]  tick
);

   logic             r_pend_vld;
   logic [CH_W-1:0]  r_pend_ch;
   logic [CNT_W-1:0] r_pend_val;
   logic             r_cfg_ready;

   logic [N_CH-1:0]  w_ld;
   logic [N_CH-1:0]  w_ld_ack;
   logic             w_ch_ok;
   logic             w_wr_acc;
   logic             w_any_ack;

   // Writes to non-existent channels are swallowed without occupying the slot
   assign w_ch_ok   = (int'(cfg_ch) < N_CH);
   assign w_wr_acc  = cfg_wr & r_cfg_ready & w_ch_ok;
   assign w_any_ack = |w_ld_ack;

   // Single pending slot: filled by an accepted write, emptied when its channel applies it
   always_ff @(posedge clk_25M) begin
      if (reset) begin
         r_pend_vld  <= 1'b0;
         r_pend_ch   <= '0;
         r_pend_val  <= '0;
         r_cfg_ready <= 1'b1;
      end else if (w_wr_acc) begin
         r_pend_vld  <= 1'b1;
         r_pend_ch   <= cfg_ch;
         r_pend_val  <= cfg_half;
         r_cfg_ready <= 1'b0;
      end else if (w_any_ack) begin
         r_pend_vld  <= 1'b0;
         r_cfg_ready <= 1'b1;
      end
   end

   assign cfg_ready = r_cfg_ready;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign w_ld[i] = r_pend_vld && (r_pend_ch == CH_W'(i));

      clk_div_ch #(
         .CNT_W    (CNT_W),
         .HALF_RST (HALF_INIT[i*CNT_W +: CNT_W])
      ) u_ch (
         .clk_25M (clk_25M),
         .reset   (reset),
         .en      (en[i]),
         .sync    (sync),
         .ld      (w_ld[i]),
         .ld_val  (r_pend_val),
         .ld_ack  (w_ld_ack[i]),
         .clk_out (clk_out[i]),
         .tick    (tick[i])
      );
   end

endmodule

// File: tb/tb_clk_div_n.sv
// tb/tb_clk_div_n.sv - directed self-checking bench for clk_div_n
module tb_clk_div_n;

   logic       clk_25M = 1'b0;
   logic       reset;
   logic [2:0] en;
   logic       sync;
   logic       cfg_wr;
   logic [1:0] cfg_ch;
   logic [7:0] cfg_half;
   logic       cfg_ready;
   logic [2:0] clk_out;
   logic [2:0] tick;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [2:0] en;
      logic [2:0] exp_clk;
      logic [2:0] exp_tick;
      logic       exp_rdy;
   } vec_t;

   vec_t tbl [12];

   // Three channels so that channel index 3 is out of range; halves 1, 3, 2
   clk_div_n #(
      .N_CH      (3),
      .CNT_W     (8),
      .HALF_INIT ({8'd2, 8'd3, 8'd1})
   ) dut (
      .clk_25M   (clk_25M),
      .reset     (reset),
      .en        (en),
      .sync      (sync),
      .cfg_wr    (cfg_wr),
      .cfg_ch    (cfg_ch),
      .cfg_half  (cfg_half),
      .cfg_ready (cfg_ready),
      .clk_out   (clk_out),
      .tick      (tick)
   );

   always #5 clk_25M = ~clk_25M;

   task automatic step();
      @(posedge clk_25M);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   // Edges until clk_out[ch] changes; -1 when it never does within the budget
   task automatic wait_change(input int ch, output int n);
      logic old;
      old = clk_out[ch];
      n = -1;
      for (int i = 1; i <= 64; i++) begin
         step();
         if (clk_out[ch] !== old) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic run_table(input string tag);
      for (int i = 0; i < 12; i++) begin
         en = tbl[i].en;
         step();
         chk($sformatf("%s%0d_clk", tag, i + 1), 32'(clk_out), 32'(tbl[i].exp_clk));
         chk($sformatf("%s%0d_tick", tag, i + 1), 32'(tick), 32'(tbl[i].exp_tick));
         chk($sformatf("%s%0d_rdy", tag, i + 1), 32'(cfg_ready), 32'(tbl[i].exp_rdy));
      end
   endtask

   initial begin
      int         n;
      logic       old0;
      logic [2:0] s_clk  [5];
      logic [2:0] s_tick [5];
      logic [2:0] w_clk  [5];
      logic [2:0] w_tick [5];
      logic       w_rdy  [5];

      // Free-running from reset: ch0 toggles every 2, ch1 every 4, ch2 every 3 edges
      tbl[0]  = '{3'b111, 3'b111, 3'b000, 1'b1};
      tbl[1]  = '{3'b111, 3'b110, 3'b000, 1'b1};
      tbl[2]  = '{3'b111, 3'b010, 3'b000, 1'b1};
      tbl[3]  = '{3'b111, 3'b001, 3'b001, 1'b1};
      tbl[4]  = '{3'b111, 3'b001, 3'b000, 1'b1};
      tbl[5]  = '{3'b111, 3'b100, 3'b100, 1'b1};
      tbl[6]  = '{3'b111, 3'b100, 3'b000, 1'b1};
      tbl[7]  = '{3'b111, 3'b111, 3'b011, 1'b1};
      tbl[8]  = '{3'b111, 3'b011, 3'b000, 1'b1};
      tbl[9]  = '{3'b111, 3'b010, 3'b000, 1'b1};
      tbl[10] = '{3'b111, 3'b010, 3'b000, 1'b1};
      tbl[11] = '{3'b111, 3'b101, 3'b101, 1'b1};

      // After sync with halves ch0=4, ch1=1, ch2=2
      s_clk  = '{3'b111, 3'b101, 3'b001, 3'b011, 3'b010};
      s_tick = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b000};
      // After sync plus same-cycle write ch2 <= 0
      w_clk  = '{3'b111, 3'b101, 3'b001, 3'b111, 3'b010};
      w_tick = '{3'b000, 3'b000, 3'b000, 3'b110, 3'b000};
      w_rdy  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

      reset = 1'b1; en = 3'b000; sync = 1'b0;
      cfg_wr = 1'b0; cfg_ch = 2'd0; cfg_half = 8'd0;
      repeat (3) step();
      chk("rst_clk", 32'(clk_out), 32'h7);
      chk("rst_tick", 32'(tick), 32'h0);
      chk("rst_rdy", 32'(cfg_ready), 32'h1);

      reset = 1'b0;
      run_table("def");

      // Enable gating on ch1: one count in, freeze for 5 edges, then 3 more to the rise
      step();
      en = 3'b101;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("gate%0d_clk1", i), 32'(clk_out[1]), 32'h0);
         chk($sformatf("gate%0d_tick1", i), 32'(tick[1]), 32'h0);
      end
      en = 3'b111;
      wait_change(1, n);
      chk("gate_resume_edges", n, 3);
      chk("gate_resume_tick1", 32'(tick[1]), 32'h1);

      // Reload ch1 from half 3 to half 1 while at count 1
      step();
      cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd1;
      step();
      cfg_wr = 1'b0;
      chk("reload_rdy_low", 32'(cfg_ready), 32'h0);
      wait_change(1, n);
      chk("reload_old_tail", n, 2);
      chk("reload_rdy_back", 32'(cfg_ready), 32'h1);
      wait_change(1, n);
      chk("reload_new_a", n, 2);
      wait_change(1, n);
      chk("reload_new_b", n, 2);

      // Write to disabled ch0: applied next edge, output holds, count restarts
      old0 = clk_out[0];
      en = 3'b110; cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd4;
      step();
      cfg_wr = 1'b0;
      chk("dis_rdy_low", 32'(cfg_ready), 32'h0);
      chk("dis_hold_a", 32'(clk_out[0]), 32'(old0));
      step();
      chk("dis_rdy_back", 32'(cfg_ready), 32'h1);
      chk("dis_hold_b", 32'(clk_out[0]), 32'(old0));
      en = 3'b111;
      wait_change(0, n);
      chk("dis_new_half", n, 5);

      // Out-of-range channel write is swallowed
      cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_half = 8'd0;
      step();
      cfg_wr = 1'b0;
      chk("bad_rdy_a", 32'(cfg_ready), 32'h1);
      step();
      chk("bad_rdy_b", 32'(cfg_ready), 32'h1);
      wait_change(1, n);
      wait_change(1, n);
      chk("bad_ch1_half", n, 2);

      // Sync realigns all channels
      sync = 1'b1;
      step();
      sync = 1'b0;
      chk("sync_clk", 32'(clk_out), 32'h7);
      chk("sync_tick", 32'(tick), 32'h0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("sync%0d_clk", i + 1), 32'(clk_out), 32'(s_clk[i]));
         chk($sformatf("sync%0d_tick", i + 1), 32'(tick), 32'(s_tick[i]));
      end

      // Sync and write in the same cycle: write waits for ch2's next toggle
      sync = 1'b1; cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_half = 8'd0;
      step();
      sync = 1'b0; cfg_wr = 1'b0;
      chk("swr_clk", 32'(clk_out), 32'h7);
      chk("swr_rdy", 32'(cfg_ready), 32'h0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("swr%0d_clk", i + 1), 32'(clk_out), 32'(w_clk[i]));
         chk($sformatf("swr%0d_tick", i + 1), 32'(tick), 32'(w_tick[i]));
         chk($sformatf("swr%0d_rdy", i + 1), 32'(cfg_ready), 32'(w_rdy[i]));
      end

      // A sync arriving while ch0's write is pending applies it immediately
      cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd1;
      step();
      cfg_wr = 1'b0;
      chk("spend_rdy_low", 32'(cfg_ready), 32'h0);
      sync = 1'b1;
      step();
      sync = 1'b0;
      chk("spend_clk", 32'(clk_out), 32'h7);
      chk("spend_rdy_back", 32'(cfg_ready), 32'h1);
      wait_change(0, n);
      chk("spend_half", n, 2);

      // Reset with a write pending: everything returns to defaults
      cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd7;
      step();
      cfg_wr = 1'b0;
      chk("mrst_pend", 32'(cfg_ready), 32'h0);
      reset = 1'b1;
      step();
      step();
      chk("mrst_clk", 32'(clk_out), 32'h7);
      chk("mrst_tick", 32'(tick), 32'h0);
      chk("mrst_rdy", 32'(cfg_ready), 32'h1);
      reset = 1'b0;
      run_table("post");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
